// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    // Converter FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Largest value representable in four BCD digits; larger inputs saturate here.
    localparam int BCD_MAX = 9999;

    // Number of BCD digits produced.
    localparam int DIGITS = 4;

    // Width of the BCD scratch register (one nibble per digit).
    localparam int SCR_W = DIGITS * 4;

    // True when an unsigned operand cannot be shown on four digits.
    function automatic logic exceeds_bcd_max(input logic [31:0] value);
        return (value > 32'(BCD_MAX));
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: adds 3 to a BCD digit of 5 or more so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3 (
    input  logic [3:0] d_in,
    output logic [3:0] d_out
);

    // Correct the digit before the shift; no carry leaves the nibble.
    always_comb begin
        d_out = d_in;
        if (d_in >= 4'd5) begin
            d_out = d_in + 4'd3;
        end else begin
            d_out = d_in;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one operand bit per clock, four BCD
// digits out. The digit registers only update on the DONE cycle, so the
// display downstream never sees a half-converted value.
module bin_to_bcd_seq #(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic             ready,
    output logic             done,
    output logic             ovf,
    output logic [3:0]       ones,
    output logic [3:0]       tens,
    output logic [3:0]       hundreds,
    output logic [3:0]       thousands
);

    import bcd_pkg::*;

    // Iteration counter only has to reach BIN_W-1.
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // Saturation value; only reachable when BIN_W is wide enough to exceed it.
    localparam logic [BIN_W-1:0] OPND_MAX = BIN_W'(BCD_MAX);

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [BIN_W-1:0]   operand_r;
    logic [SCR_W-1:0]   scratch_r;
    logic               ovf_pending_r;
    logic               ready_r;
    logic               done_r;
    logic               ovf_r;
    logic [3:0]         ones_r;
    logic [3:0]         tens_r;
    logic [3:0]         hundreds_r;
    logic [3:0]         thousands_r;

    logic [SCR_W-1:0]   adj_s;
    logic [SCR_W-1:0]   shift_scratch_s;
    logic [BIN_W-1:0]   shift_operand_s;
    logic [BIN_W-1:0]   cap_operand_s;
    logic               cap_ovf_s;

    // One add-3 corrector per scratch nibble; nibbles are independent.
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .d_in  (scratch_r[4*g +: 4]),
            .d_out (adj_s[4*g +: 4])
        );
    end

    // Next {scratch, operand} after one correct-then-shift-left iteration.
    always_comb begin
        shift_scratch_s = {adj_s[SCR_W-2:0], operand_r[BIN_W-1]};
        shift_operand_s = {operand_r[BIN_W-2:0], 1'b0};
    end

    // Operand capture with saturation of anything above four digits.
    always_comb begin
        cap_ovf_s     = 1'b0;
        cap_operand_s = bin_in;
        if (exceeds_bcd_max(32'(bin_in))) begin
            cap_ovf_s     = 1'b1;
            cap_operand_s = OPND_MAX;
        end else begin
            cap_ovf_s     = 1'b0;
            cap_operand_s = bin_in;
        end
    end

    // Converter FSM with registered handshake, flag and digit outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            cnt_r         <= {CNT_W{1'b0}};
            operand_r     <= {BIN_W{1'b0}};
            scratch_r     <= {SCR_W{1'b0}};
            ovf_pending_r <= 1'b0;
            ready_r       <= 1'b1;
            done_r        <= 1'b0;
            ovf_r         <= 1'b0;
            ones_r        <= 4'd0;
            tens_r        <= 4'd0;
            hundreds_r    <= 4'd0;
            thousands_r   <= 4'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        operand_r     <= cap_operand_s;
                        ovf_pending_r <= cap_ovf_s;
                        scratch_r     <= {SCR_W{1'b0}};
                        cnt_r         <= {CNT_W{1'b0}};
                        ready_r       <= 1'b0;
                        state_r       <= SHIFT;
                    end else begin
                        ready_r <= 1'b1;
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    done_r    <= 1'b0;
                    scratch_r <= shift_scratch_s;
                    operand_r <= shift_operand_s;
                    if (cnt_r == CNT_LAST) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        ready_r <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                        ready_r <= 1'b0;
                        state_r <= SHIFT;
                    end
                end
                DONE: begin
                    // Publish the finished digits; this is the only digit update.
                    ones_r      <= scratch_r[3:0];
                    tens_r      <= scratch_r[7:4];
                    hundreds_r  <= scratch_r[11:8];
                    thousands_r <= scratch_r[15:12];
                    ovf_r       <= ovf_pending_r;
                    done_r      <= 1'b1;
                    if (start) begin
                        operand_r     <= cap_operand_s;
                        ovf_pending_r <= cap_ovf_s;
                        scratch_r     <= {SCR_W{1'b0}};
                        cnt_r         <= {CNT_W{1'b0}};
                        ready_r       <= 1'b0;
                        state_r       <= SHIFT;
                    end else begin
                        ready_r <= 1'b1;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= {CNT_W{1'b0}};
                    ready_r <= 1'b1;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Outputs are driven straight from registers.
    always_comb begin
        ready     = ready_r;
        done      = done_r;
        ovf       = ovf_r;
        ones      = ones_r;
        tens      = tens_r;
        hundreds  = hundreds_r;
        thousands = thousands_r;
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq (BIN_W = 14).
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [13:0] bin_in;
    logic        ready;
    logic        done;
    logic        ovf;
    logic [3:0]  ones;
    logic [3:0]  tens;
    logic [3:0]  hundreds;
    logic [3:0]  thousands;

    int checks = 0;
    int errors = 0;

    bin_to_bcd_seq #(.BIN_W(14)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bin_in    (bin_in),
        .ready     (ready),
        .done      (done),
        .ovf       (ovf),
        .ones      (ones),
        .tens      (tens),
        .hundreds  (hundreds),
        .thousands (thousands)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] digits();
        return {thousands, hundreds, tens, ones};
    endfunction

    // Start one conversion and return cycles from accepting edge to done (-1 on timeout).
    task automatic run_conv(input logic [13:0] v, output int lat);
        int n;
        lat = -1;
        n = 0;
        while (!ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        bin_in = v;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = 14'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ready !== 1'b1 || done !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got ready=%b done=%b ovf=%b expected 1 0 0", ready, done, ovf);
        end
        checks++;
        if (digits() !== 16'h0000) begin
            errors++;
            $display("FAIL reset_digits: got %h expected 0000", digits());
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat;
        lat = -1;
        bin_in = 14'd1234;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            // a stray start mid-conversion must be ignored
            if (i == 5) begin
                start  = 1'b1;
                bin_in = 14'd9;
            end else begin
                start  = 1'b0;
            end
            if (i == 3) begin
                checks++;
                if (ready !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_busy: got ready=%b expected 0", ready);
                end
            end
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        start = 1'b0;
        checks++;
        if (lat !== 15) begin
            errors++;
            $display("FAIL basic_latency: got %0d expected 15", lat);
        end
        checks++;
        if (digits() !== 16'h1234 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL basic_digits: got %h ovf=%b expected 1234 ovf=0", digits(), ovf);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || ready !== 1'b1 || digits() !== 16'h1234) begin
            errors++;
            $display("FAIL basic_pulse: got done=%b ready=%b digits=%h expected 0 1 1234", done, ready, digits());
        end
    endtask

    task automatic test_bounds();
        int lat;
        run_conv(14'd0, lat);
        checks++;
        if (lat !== 15 || digits() !== 16'h0000 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL zero_conv: got lat=%0d digits=%h ovf=%b expected 15 0000 0", lat, digits(), ovf);
        end
        run_conv(14'd9999, lat);
        checks++;
        if (lat !== 15 || digits() !== 16'h9999 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL max_conv: got lat=%0d digits=%h ovf=%b expected 15 9999 0", lat, digits(), ovf);
        end
    endtask

    task automatic test_overflow();
        int lat;
        run_conv(14'd16383, lat);
        checks++;
        if (lat !== 15 || digits() !== 16'h9999 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_conv: got lat=%0d digits=%h ovf=%b expected 15 9999 1", lat, digits(), ovf);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_hold: got %b expected 1", ovf);
        end
        run_conv(14'd42, lat);
        checks++;
        if (lat !== 15 || digits() !== 16'h0042 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got lat=%0d digits=%h ovf=%b expected 15 0042 0", lat, digits(), ovf);
        end
    endtask

    task automatic test_back_to_back();
        int lat1;
        int lat2;
        int bad;
        logic [15:0] prev;
        lat1 = -1;
        lat2 = -1;
        bad  = 0;
        prev = digits();
        bin_in = 14'd7;
        start  = 1'b1;
        @(posedge clk); #1;
        bin_in = 14'd805;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat1 = i;
                break;
            end
            if (digits() !== prev) bad++;
        end
        checks++;
        if (lat1 !== 15 || digits() !== 16'h0007) begin
            errors++;
            $display("FAIL b2b_first: got lat=%0d digits=%h expected 15 0007", lat1, digits());
        end
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: got ready=%b expected 0", ready);
        end
        start = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat2 = i;
                break;
            end
            if (digits() !== 16'h0007) bad++;
        end
        checks++;
        if (lat2 !== 15 || digits() !== 16'h0805) begin
            errors++;
            $display("FAIL b2b_second: got lat=%0d digits=%h expected 15 0805", lat2, digits());
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL b2b_stable: got %0d digit changes outside done expected 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        seen = 0;
        bin_in = 14'd5678;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if (digits() !== 16'h0000 || ready !== 1'b1 || ovf !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state: got digits=%h ready=%b ovf=%b done=%b expected 0000 1 0 0",
                     digits(), ready, ovf, done);
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        checks++;
        if (seen !== 0 || digits() !== 16'h0000) begin
            errors++;
            $display("FAIL midrst_nodone: got %0d done pulses digits=%h expected 0 0000", seen, digits());
        end
        run_conv(14'd5678, lat);
        checks++;
        if (lat !== 15 || digits() !== 16'h5678) begin
            errors++;
            $display("FAIL midrst_retry: got lat=%0d digits=%h expected 15 5678", lat, digits());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bounds();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
